field_entry_ctrl: RTL and testbench
===================================

FIELD_ENTRY_CTRL -- requirements
Module: field_entry_ctrl

Interface
REQ-001 Parameter CH, default 3: number of target channels (1..8).
REQ-002 Parameter FIELDS, default 3: maximum fields per channel (1..4).
REQ-003 Parameter FW, default 7: width of each field in bits (1..8).
REQ-004 Parameter NFIELDS, default {3'd2,3'd3,3'd2}: packed field count per channel; channel i uses NFIELDS[3i+:3], legal range 1..FIELDS.
REQ-005 Parameter TIMEOUT, default 32'd500_000_000: idle-cycle abort limit in COLLECT; 0 disables timeout.
REQ-006 clk  input  1  system clock; all state updates on the rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 btn_sel  input  CH  one-cycle debounced pulses; bit i requests entry for channel i.
REQ-009 btn_next  input  1  one-cycle pulse; accept sw as the current field.
REQ-010 btn_back  input  1  one-cycle pulse; return to the previous field.
REQ-011 btn_cancel  input  1  one-cycle pulse; abort entry.
REQ-012 sw  input  FW  candidate field value.
REQ-013 field_max  input  FW  inclusive upper limit for the field addressed by (cur_ch, step); driven combinationally outside the block.
REQ-014 busy  output  1  high while in COLLECT.
REQ-015 cur_ch  output  3  channel being entered; holds its last value when idle.
REQ-016 step  output  2  index of the field being entered.
REQ-017 data_out  output  FIELDS*FW  last committed record; field k at [k*FW+:FW], field 0 entered first.
REQ-018 ow  output  CH  one-cycle commit strobe, one bit per channel.
REQ-019 err  output  1  one-cycle pulse on an out-of-range value.
REQ-020 tout  output  1  one-cycle pulse on a timeout abort.

Function
REQ-021 State machine: IDLE, COLLECT.
- IDLE -> COLLECT on any btn_sel bit.
- Lowest set index wins.
- Entry sets cur_ch to that index, step=0, and clears the working buffer.
REQ-022 In IDLE, btn_next, btn_back and btn_cancel are ignored. In COLLECT, btn_sel is ignored.
REQ-023 In COLLECT, priority per cycle is cancel > back > next; exactly one action is taken.
REQ-024 Cancel: go to IDLE; data_out unchanged; no ow pulse.
REQ-025 Back at step>0: step decrements and the working field is kept. Back at step=0 behaves as cancel.
REQ-026 Next with sw<=field_max (unsigned): working[step] is written with sw. Then:
- if step < nf-1: step increments;
- if step == nf-1 (commit): see REQ-027.
REQ-027 Commit: on the next cycle, data_out receives the working buffer including the final field, ow[cur_ch] pulses high for exactly one cycle, and state is IDLE.
REQ-028 On commit, fields at index >= nf of the committing channel are driven to 0 in data_out.
REQ-029 Next with sw>field_max: err pulses one cycle later; step and buffer are unchanged; no timeout reload is suppressed (the press still counts as activity).
REQ-030 Timeout:
- the counter reloads on entry to COLLECT and on any btn_next, btn_back or btn_cancel pulse;
- reaching TIMEOUT cycles with no press aborts as cancel, with tout pulsing one cycle;
- a press in the expiry cycle takes precedence over the timeout.
REQ-031 The timeout counter width is 32 bits, with no wrap. When TIMEOUT=0 the counter never expires.
REQ-032 At most one ow bit is high in any cycle. ow, err and tout are never high in the same cycle.
REQ-033 busy is registered: high the cycle after the btn_sel pulse, low the cycle after the commit or abort.

Reset
REQ-034 While rst=0, asynchronously:
- state=IDLE;
- busy=0, cur_ch=0, step=0;
- data_out=0, working buffer=0;
- ow=0, err=0, tout=0;
- timeout counter=0.
REQ-035 Reset asserted during COLLECT discards the entry; no ow pulse is produced.

Verification (CH=3, FIELDS=3, FW=7, NFIELDS={2,3,2}, TIMEOUT=16)
REQ-036 Time entry: btn_sel=001; then next with sw=13 (field_max=23); then next with sw=45 (field_max=59) -> ow=001 for one cycle, data_out=(0,45,13) from field 2 down to field 0, busy=0.
REQ-037 Date entry with range error: btn_sel=010; next sw=21; next sw=14 with field_max=12 -> err pulse, step stays 1; next sw=6; next sw=30 -> ow=010, data_out=(30,6,21).
REQ-038 Back/cancel: btn_sel=100; next sw=7; back -> step=0; back -> IDLE, data_out unchanged, ow=000.
REQ-039 Priority: btn_sel=110 selects ch1; in COLLECT, next+cancel in the same cycle -> abort, no ow; btn_sel during COLLECT does not change cur_ch.
REQ-040 Timeout: enter ch0 and apply no press for 16 cycles -> tout pulse, IDLE. A next press in the expiry cycle -> no tout, step advances.
REQ-041 Reset: rst low mid-entry at step=1 -> all outputs 0 immediately. After release, btn_next produces no response until btn_sel.

Source files
------------

// File: rtl/field_entry_ctrl.sv
// Multi-field value entry controller: selects a channel, collects range-checked
// fields one press at a time, and commits the record with a per-channel strobe.
module field_entry_ctrl #(
  parameter int unsigned     CH      = 3,
  parameter int unsigned     FIELDS  = 3,
  parameter int unsigned     FW      = 7,
  parameter logic [3*CH-1:0] NFIELDS = {3'd2, 3'd3, 3'd2},
  parameter logic [31:0]     TIMEOUT = 32'd500_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CH-1:0]        btn_sel,
  input  logic                 btn_next,
  input  logic                 btn_back,
  input  logic                 btn_cancel,
  input  logic [FW-1:0]        sw,
  input  logic [FW-1:0]        field_max,
  output logic                 busy,
  output logic [2:0]           cur_ch,
  output logic [1:0]           step,
  output logic [FIELDS*FW-1:0] data_out,
  output logic [CH-1:0]        ow,
  output logic                 err,
  output logic                 tout
);

  localparam int unsigned DW = FIELDS * FW;

  typedef enum logic {IDLE, COLLECT} state_t;

  state_t         state, state_n;
  logic           busy_n, err_n, tout_n;
  logic [2:0]     cur_ch_n, sel_idx, nf;
  logic [1:0]     step_n;
  logic [DW-1:0]  data_n, work, work_n;
  logic [CH-1:0]  ow_n;
  logic [31:0]    tcnt, tcnt_n;
  logic           press, last_field, expire;

  // Lowest requested channel, field count of the active channel, timer expiry
  always_comb begin
    sel_idx = '0;
    for (int i = int'(CH) - 1; i >= 0; i--) begin
      if (btn_sel[i]) sel_idx = 3'(i);
    end
    nf = 3'd1;
    for (int i = 0; i < int'(CH); i++) begin
      if (cur_ch == 3'(i)) nf = NFIELDS[i*3 +: 3];
    end
    press      = btn_next | btn_back | btn_cancel;
    last_field = ({1'b0, step} == (nf - 3'd1));
    expire     = (TIMEOUT != 32'd0) && (tcnt == (TIMEOUT - 32'd1));
  end

  always_comb begin
    state_n  = state;
    busy_n   = busy;
    cur_ch_n = cur_ch;
    step_n   = step;
    data_n   = data_out;
    work_n   = work;
    ow_n     = '0;
    err_n    = 1'b0;
    tout_n   = 1'b0;
    tcnt_n   = tcnt;
    case (state)
      IDLE: begin
        if (|btn_sel) begin
          state_n  = COLLECT;
          busy_n   = 1'b1;
          cur_ch_n = sel_idx;
          step_n   = '0;
          work_n   = '0;
          tcnt_n   = '0;
        end
      end
      COLLECT: begin
        // Any press counts as activity, even a rejected value
        if (press) tcnt_n = '0;
        else if (tcnt != '1) tcnt_n = tcnt + 32'd1;
        if (btn_cancel || (btn_back && step == 2'd0)) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          step_n  = '0;
          tcnt_n  = '0;
        end else if (btn_back) begin
          step_n = step - 2'd1;
        end else if (btn_next) begin
          if (sw > field_max) begin
            err_n = 1'b1;
          end else begin
            work_n[int'(step)*FW +: FW] = sw;
            if (last_field) begin
              for (int k = 0; k < int'(FIELDS); k++) begin
                data_n[k*FW +: FW] = (3'(k) < nf) ? work_n[k*FW +: FW] : '0;
              end
              for (int i = 0; i < int'(CH); i++) begin
                if (cur_ch == 3'(i)) ow_n[i] = 1'b1;
              end
              state_n = IDLE;
              busy_n  = 1'b0;
              step_n  = '0;
              tcnt_n  = '0;
            end else begin
              step_n = step + 2'd1;
            end
          end
        end else if (expire) begin
          tout_n  = 1'b1;
          state_n = IDLE;
          busy_n  = 1'b0;
          step_n  = '0;
          tcnt_n  = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      cur_ch   <= '0;
      step     <= '0;
      data_out <= '0;
      work     <= '0;
      ow       <= '0;
      err      <= 1'b0;
      tout     <= 1'b0;
      tcnt     <= '0;
    end else begin
      state    <= state_n;
      busy     <= busy_n;
      cur_ch   <= cur_ch_n;
      step     <= step_n;
      data_out <= data_n;
      work     <= work_n;
      ow       <= ow_n;
      err      <= err_n;
      tout     <= tout_n;
      tcnt     <= tcnt_n;
    end
  end

endmodule

// File: tb/tb_field_entry_ctrl.sv
// Self-checking bench for field_entry_ctrl: directed vector table, hand-written
// timeout/reset sequences, and random stimulus against a behavioural model.
module tb_field_entry_ctrl;

  localparam int CH = 3, FIELDS = 3, FW = 7, TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  btn_sel = '0;
  logic        btn_next = 1'b0, btn_back = 1'b0, btn_cancel = 1'b0;
  logic [6:0]  sw = '0, field_max = '0;
  logic        busy, err, tout;
  logic [2:0]  cur_ch, ow;
  logic [1:0]  step;
  logic [20:0] data_out;

  field_entry_ctrl #(.TIMEOUT(32'd16)) dut (
    .clk(clk), .rst(rst), .btn_sel(btn_sel), .btn_next(btn_next),
    .btn_back(btn_back), .btn_cancel(btn_cancel), .sw(sw),
    .field_max(field_max), .busy(busy), .cur_ch(cur_ch), .step(step),
    .data_out(data_out), .ow(ow), .err(err), .tout(tout)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Behavioural model: an entry session with a list of fields and an idle count
  int nf_tab[3] = '{2, 3, 2};
  int m_busy, m_ch, m_step, m_ow, m_err, m_tout, m_idle;
  int m_fields[FIELDS];
  int m_data[FIELDS];

  task automatic model_reset();
    m_busy = 0; m_ch = 0; m_step = 0; m_ow = 0; m_err = 0; m_tout = 0; m_idle = 0;
    for (int k = 0; k < FIELDS; k++) begin m_fields[k] = 0; m_data[k] = 0; end
  endtask

  task automatic model_leave();
    m_busy = 0; m_step = 0;
  endtask

  task automatic model_update();
    m_ow = 0; m_err = 0; m_tout = 0;
    if (m_busy == 0) begin
      if (btn_sel != 3'b000) begin
        for (int i = CH - 1; i >= 0; i--) if (btn_sel[i]) m_ch = i;
        m_busy = 1; m_step = 0; m_idle = 0;
        for (int k = 0; k < FIELDS; k++) m_fields[k] = 0;
      end
    end else begin
      if (btn_cancel || (btn_back && m_step == 0)) model_leave();
      else if (btn_back) m_step--;
      else if (btn_next) begin
        if (int'(sw) > int'(field_max)) m_err = 1;
        else begin
          m_fields[m_step] = int'(sw);
          if (m_step == nf_tab[m_ch] - 1) begin
            for (int k = 0; k < FIELDS; k++) m_data[k] = (k < nf_tab[m_ch]) ? m_fields[k] : 0;
            m_ow = 1 << m_ch;
            model_leave();
          end else m_step++;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin m_tout = 1; model_leave(); end
      end
      if (btn_next || btn_back || btn_cancel) m_idle = 0;
    end
  endtask

  function automatic int model_data();
    int d = 0;
    for (int k = 0; k < FIELDS; k++) d |= m_data[k] << (k * FW);
    return d;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    chk("busy", 32'(busy), 32'(m_busy));
    chk("cur_ch", 32'(cur_ch), 32'(m_ch));
    chk("step", 32'(step), 32'(m_step));
    chk("data_out", 32'(data_out), 32'(model_data()));
    chk("ow", 32'(ow), 32'(m_ow));
    chk("err", 32'(err), 32'(m_err));
    chk("tout", 32'(tout), 32'(m_tout));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    chk_model();
  endtask

  task automatic set_in(int sel, int nx, int bk, int cn, int s, int fm);
    btn_sel = 3'(sel); btn_next = 1'(nx); btn_back = 1'(bk); btn_cancel = 1'(cn);
    sw = 7'(s); field_max = 7'(fm);
  endtask

  task automatic idle_in();
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    int sel, nx, bk, cn, sw, fm;
    int busy, ch, step, ow, err, tout, data;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(int sel, int nx, int bk, int cn, int s, int fm,
                              int b, int ch, int st, int o, int e, int t, int d);
    vec_t v;
    v.sel = sel; v.nx = nx; v.bk = bk; v.cn = cn; v.sw = s; v.fm = fm;
    v.busy = b; v.ch = ch; v.step = st; v.ow = o; v.err = e; v.tout = t; v.data = d;
    return v;
  endfunction

  initial begin
    // Time entry, date entry with range error, back/cancel, priority
    tbl[0]  = mk(3'b001, 0, 0, 0,  0,  0, 1, 0, 0, 3'b000, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 13, 23, 1, 0, 1, 3'b000, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 45, 59, 0, 0, 0, 3'b001, 0, 0, 5773);
    tbl[3]  = mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 3'b000, 0, 0, 5773);
    tbl[4]  = mk(3'b010, 0, 0, 0,  0,  0, 1, 1, 0, 3'b000, 0, 0, 5773);
    tbl[5]  = mk(0, 1, 0, 0, 21, 31, 1, 1, 1, 3'b000, 0, 0, 5773);
    tbl[6]  = mk(0, 1, 0, 0, 14, 12, 1, 1, 1, 3'b000, 1, 0, 5773);
    tbl[7]  = mk(0, 1, 0, 0,  6, 31, 1, 1, 2, 3'b000, 0, 0, 5773);
    tbl[8]  = mk(0, 1, 0, 0, 30, 31, 0, 1, 0, 3'b010, 0, 0, 492309);
    tbl[9]  = mk(3'b100, 0, 0, 0,  0,  0, 1, 2, 0, 3'b000, 0, 0, 492309);
    tbl[10] = mk(0, 1, 0, 0,  7, 31, 1, 2, 1, 3'b000, 0, 0, 492309);
    tbl[11] = mk(0, 0, 1, 0,  0,  0, 1, 2, 0, 3'b000, 0, 0, 492309);
    tbl[12] = mk(0, 0, 1, 0,  0,  0, 0, 2, 0, 3'b000, 0, 0, 492309);
    tbl[13] = mk(3'b110, 0, 0, 0,  0,  0, 1, 1, 0, 3'b000, 0, 0, 492309);
    tbl[14] = mk(3'b001, 0, 0, 0,  0,  0, 1, 1, 0, 3'b000, 0, 0, 492309);
    tbl[15] = mk(0, 1, 0, 1,  1, 31, 0, 1, 0, 3'b000, 0, 0, 492309);

    model_reset();
    idle_in();
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_ow", 32'(ow), 0);
    @(posedge clk); #1 rst = 1'b1;
    tick();

    for (int i = 0; i < 16; i++) begin
      set_in(tbl[i].sel, tbl[i].nx, tbl[i].bk, tbl[i].cn, tbl[i].sw, tbl[i].fm);
      tick();
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_ch", i), 32'(cur_ch), 32'(tbl[i].ch));
      chk($sformatf("v%0d_step", i), 32'(step), 32'(tbl[i].step));
      chk($sformatf("v%0d_ow", i), 32'(ow), 32'(tbl[i].ow));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].err));
      chk($sformatf("v%0d_tout", i), 32'(tout), 32'(tbl[i].tout));
      chk($sformatf("v%0d_data", i), 32'(data_out), 32'(tbl[i].data));
    end

    // Timeout after 16 quiet cycles
    set_in(3'b001, 0, 0, 0, 0, 0); tick();
    idle_in();
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to_pre_busy", 32'(busy), 1);
    chk("to_pre_tout", 32'(tout), 0);
    tick();
    chk("to_tout", 32'(tout), 1);
    chk("to_busy", 32'(busy), 0);
    tick();
    chk("to_pulse_end", 32'(tout), 0);

    // A press in the expiry cycle wins over the timeout
    set_in(3'b001, 0, 0, 0, 0, 0); tick();
    idle_in();
    for (int i = 0; i < TO - 1; i++) tick();
    set_in(0, 1, 0, 0, 3, 10); tick();
    chk("tp_tout", 32'(tout), 0);
    chk("tp_step", 32'(step), 1);
    chk("tp_busy", 32'(busy), 1);
    set_in(0, 0, 0, 1, 0, 0); tick();

    // Asynchronous reset mid-entry at step 1
    set_in(3'b010, 0, 0, 0, 0, 0); tick();
    set_in(0, 1, 0, 0, 5, 9); tick();
    chk("rs_step_pre", 32'(step), 1);
    idle_in();
    #3 rst = 1'b0;
    #1;
    model_reset();
    chk_model();
    @(posedge clk); #1 rst = 1'b1;
    set_in(0, 1, 0, 0, 2, 9); tick();
    chk("rs_next_busy", 32'(busy), 0);
    chk("rs_next_ow", 32'(ow), 0);
    set_in(0, 0, 0, 0, 0, 0); tick();

    // Random stimulus with occasional quiet stretches to reach timeouts
    begin
      int quiet = 0;
      for (int n = 0; n < 800; n++) begin
        if (quiet > 0) begin
          idle_in();
          quiet--;
        end else if ($urandom_range(0, 39) == 0) begin
          idle_in();
          quiet = int'($urandom_range(10, 20));
        end else begin
          set_in(($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : 0,
                 ($urandom_range(0, 2) == 0) ? 1 : 0,
                 ($urandom_range(0, 9) == 0) ? 1 : 0,
                 ($urandom_range(0, 19) == 0) ? 1 : 0,
                 int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
        end
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
